// File: rtl/alu_exec_stage_pkg.sv
// ALU execute-stage shared types: control encodings, ALUOp/funct codes
// and the combinational control decoder.
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_AND  = 4'd0,
    CTRL_OR   = 4'd1,
    CTRL_ADD  = 4'd2,
    CTRL_SUB  = 4'd6,
    CTRL_SLT  = 4'd7,
    CTRL_NOR  = 4'd12,
    CTRL_NAND = 4'd13
  } alu_ctrl_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_RAW   = 2'b11;

  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_NAND = 6'h2C;

  typedef struct packed {
    alu_ctrl_t ctrl;
    logic      illegal;
  } dec_t;

  function automatic dec_t alu_decode(
    input logic [1:0] op,
    input logic [5:0] funct
  );
    dec_t d;
    d.ctrl    = CTRL_AND;
    d.illegal = 1'b0;
    unique case (op)
      OP_ADD: d.ctrl = CTRL_ADD;
      OP_SUB: d.ctrl = CTRL_SUB;
      OP_RTYPE: begin
        case (funct)
          F_AND:   d.ctrl = CTRL_AND;
          F_OR:    d.ctrl = CTRL_OR;
          F_ADD:   d.ctrl = CTRL_ADD;
          F_SUB:   d.ctrl = CTRL_SUB;
          F_SLT:   d.ctrl = CTRL_SLT;
          F_NOR:   d.ctrl = CTRL_NOR;
          F_NAND:  d.ctrl = CTRL_NAND;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_RAW: begin
        if (funct[3:0] inside {4'd0, 4'd1, 4'd2, 4'd6,
                               4'd7, 4'd12, 4'd13})
          d.ctrl = alu_ctrl_t'(funct[3:0]);
        else
          d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Upstream/downstream handshake bundle for the ALU execute stage.
// master = producer/consumer side, slave = the stage itself.
interface alu_exec_stage_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_a;
  logic [WIDTH-1:0]      in_b;
  logic [1:0]            in_alu_op;
  logic [5:0]            in_funct;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_result;
  logic                  out_zero;
  logic                  out_overflow;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_illegal;

  modport master (
    output in_valid, in_a, in_b, in_alu_op,
    output in_funct, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_zero, out_overflow, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_a, in_b, in_alu_op,
    input  in_funct, in_rd, flush, out_ready,
    output in_ready, out_valid, out_result,
    output out_zero, out_overflow, out_rd, out_illegal
  );
endinterface

// File: rtl/fullALU.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT/NOR/NAND with Zero and
// signed Overflow (SLT reports the overflow of its internal subtract).
module fullALU #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUCtrl,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;

  assign sum     = A + B;
  assign diff    = A - B;
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                   (sum[WIDTH-1] != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                   (diff[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    Result   = '0;
    Overflow = 1'b0;
    case (ALUCtrl)
      4'd0:  Result = A & B;
      4'd1:  Result = A | B;
      4'd2: begin
        Result   = sum;
        Overflow = add_ovf;
      end
      4'd6: begin
        Result   = diff;
        Overflow = sub_ovf;
      end
      4'd7: begin
        Result[0] = diff[WIDTH-1] ^ sub_ovf;
        Overflow  = sub_ovf;
      end
      4'd12: Result = ~(A | B);
      4'd13: Result = ~(A & B);
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);
endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage execute pipeline: ID/EX register feeding fullALU, then an
// EX/WB result register, both with valid/ready back-pressure and flush.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic             clk,
  input logic             reset_n,
  alu_exec_stage_if.slave io
);
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]      s1_a_q, s1_a_d;
  logic [WIDTH-1:0]      s1_b_q, s1_b_d;
  alu_ctrl_t             s1_ctrl_q, s1_ctrl_d;
  logic [REG_ADDR_W-1:0] s1_rd_q, s1_rd_d;
  logic                  s1_ill_q, s1_ill_d;
  logic [WIDTH-1:0]      s2_res_q, s2_res_d;
  logic                  s2_zero_q, s2_zero_d;
  logic                  s2_ovf_q, s2_ovf_d;
  logic [REG_ADDR_W-1:0] s2_rd_q, s2_rd_d;
  logic                  s2_ill_q, s2_ill_d;

  logic             s2_adv, s1_adv;
  logic             s1_load, s2_load;
  dec_t             dec;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             alu_ovf;

  assign dec     = alu_decode(io.in_alu_op, io.in_funct);
  assign s2_adv  = !s2_valid_q || io.out_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign s1_load = io.in_valid && s1_adv && !io.flush;
  assign s2_load = s1_valid_q && s2_adv && !io.flush;

  fullALU #(.WIDTH(WIDTH)) u_alu (
    .A        (s1_a_q),
    .B        (s1_b_q),
    .ALUCtrl  (s1_ctrl_q),
    .Result   (alu_res),
    .Zero     (alu_zero),
    .Overflow (alu_ovf)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ctrl_d  = s1_ctrl_q;
    s1_rd_d    = s1_rd_q;
    s1_ill_d   = s1_ill_q;
    s2_res_d   = s2_res_q;
    s2_zero_d  = s2_zero_q;
    s2_ovf_d   = s2_ovf_q;
    s2_rd_d    = s2_rd_q;
    s2_ill_d   = s2_ill_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = io.in_a;
      s1_b_d     = io.in_b;
      s1_ctrl_d  = dec.ctrl;
      s1_rd_d    = io.in_rd;
      s1_ill_d   = dec.illegal;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_rd_d    = s1_rd_q;
      s2_ill_d   = s1_ill_q;
      // illegal ops present a clean all-zero result
      s2_res_d   = s1_ill_q ? '0 : alu_res;
      s2_zero_d  = !s1_ill_q && alu_zero;
      s2_ovf_d   = !s1_ill_q && alu_ovf;
    end else if (io.out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (io.flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_rd_q    <= '0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_zero_q  <= s2_zero_d;
      s2_ovf_q   <= s2_ovf_d;
      s2_rd_q    <= s2_rd_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_a_q    <= s1_a_d;
    s1_b_q    <= s1_b_d;
    s1_ctrl_q <= s1_ctrl_d;
    s1_rd_q   <= s1_rd_d;
    s1_ill_q  <= s1_ill_d;
  end

  assign io.in_ready     = s1_adv || io.flush;
  assign io.out_valid    = s2_valid_q;
  assign io.out_result   = s2_res_q;
  assign io.out_zero     = s2_zero_q;
  assign io.out_overflow = s2_ovf_q;
  assign io.out_rd       = s2_rd_q;
  assign io.out_illegal  = s2_ill_q;
endmodule
